// File: rtl/lshifter_seq.sv
// lshifter_seq: multi-cycle logical left shifter with valid/ready handshakes.
// One request at a time: the operand is latched, shifted in log2(WIDTH)
// conditional power-of-two stages (one per cycle), then the result is held
// until the consumer takes it. Latency is fixed regardless of the shift amount.
module lshifter_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [31:0]      y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             lost,
    output logic             busy
);

    // Number of shift stages, and a counter wide enough to also hold STAGES
    // itself: k counts up to STAGES and sits there for one cycle before DONE,
    // which is what gives the log2(WIDTH)+1 edge latency.
    localparam int STAGES = $clog2(WIDTH);
    localparam int KW     = $clog2(STAGES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    // Only the low stage-select bits of y are kept; the upper bits matter
    // solely for the y >= WIDTH decision, which is resolved at accept time.
    logic [STAGES-1:0] ys_q, ys_d;
    logic [KW-1:0]     k_q, k_d;
    logic              lost_q, lost_d;

    logic [31:0]       stage_amt;
    logic [WIDTH-1:0]  spill;

    // Per-stage shift distance (2^k) and the bits of acc that would leave
    // the top of the word if this stage shifts.
    always_comb begin
        stage_amt = 32'd1 << k_q;
        spill     = acc_q >> (32'(WIDTH) - stage_amt);
    end

    // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        // NOTE: every signal gets a hold value first so no path through the
        // case statement leaves one unassigned, which would infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        ys_d    = ys_q;
        k_d     = k_q;
        lost_d  = lost_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ys_d    = y[STAGES-1:0];
                    k_d     = '0;
                    state_d = SHIFT;
                    if (y >= 32'(WIDTH)) begin
                        // Everything is shifted out; stages still run on zero.
                        acc_d  = '0;
                        lost_d = |x;
                    end else begin
                        acc_d  = x;
                        lost_d = 1'b0;
                    end
                end
            end

            SHIFT: begin
                if (k_q == KW'(STAGES)) begin
                    state_d = DONE;
                end else begin
                    if (ys_q[k_q[$clog2(STAGES)-1:0]]) begin
                        acc_d  = acc_q << stage_amt;
                        lost_d = lost_q | (|spill);
                    end
                    k_d = k_q + KW'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ys_q    <= '0;
            k_q     <= '0;
            lost_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q <= state_d;
            acc_q   <= acc_d;
            ys_q    <= ys_d;
            k_q     <= k_d;
            lost_q  <= lost_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign z         = acc_q;
    assign lost      = lost_q;

endmodule
